// File: rtl/sudoku_io_ctrl_if.sv
// Bus bundle between the sudoku I/O controller and its environment:
// cell input stream, cell output stream, solver memory port, solver control
// and status. The master modport is the controller side.
interface sudoku_io_ctrl_if #(
    parameter int VW = 4,
    parameter int TW = 32,
    parameter int AW = 7
);
    logic          i_in_valid;
    logic          o_in_ready;
    logic [VW-1:0] i_in_data;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [VW-1:0] o_out_data;
    logic          o_out_last;
    logic          o_mem_we;
    logic          o_mem_re;
    logic [AW-1:0] o_mem_addr;
    logic [VW-1:0] o_mem_wdata;
    logic [VW-1:0] i_mem_rdata;
    logic          o_solver_start;
    logic          i_solver_done;
    logic [TW-1:0] i_timeout_limit;
    logic          o_busy;
    logic          o_timeout;
    logic          o_err_value;

    modport master (
        input  i_in_valid, i_in_data, i_out_ready, i_mem_rdata,
               i_solver_done, i_timeout_limit,
        output o_in_ready, o_out_valid, o_out_data, o_out_last,
               o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata,
               o_solver_start, o_busy, o_timeout, o_err_value
    );

    modport slave (
        output i_in_valid, i_in_data, i_out_ready, i_mem_rdata,
               i_solver_done, i_timeout_limit,
        input  o_in_ready, o_out_valid, o_out_data, o_out_last,
               o_mem_we, o_mem_re, o_mem_addr, o_mem_wdata,
               o_solver_start, o_busy, o_timeout, o_err_value
    );
endinterface

// File: rtl/sudoku_io_ctrl.sv
// Sudoku board I/O controller: streams a board into the solver memory,
// kicks the solver, waits for done (with optional timeout), then streams
// the board back out of memory one cell every two cycles.
module sudoku_io_ctrl #(
    parameter int BOX = 3,
    parameter int VW  = 4,
    parameter int TW  = 32,
    parameter int AW  = $clog2(BOX*BOX*BOX*BOX)
) (
    input  logic             clk,
    input  logic             rst_n,
    sudoku_io_ctrl_if.master bus
);
    localparam int N = BOX*BOX;
    localparam int C = N*N;
    localparam logic [AW-1:0] LAST_CELL = AW'(C-1);
    localparam logic [VW-1:0] MAX_VAL   = VW'(N);

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        KICK   = 3'd1,
        WAIT   = 3'd2,
        RD_REQ = 3'd3,
        RD_OUT = 3'd4
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] cell_cnt_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          timeout_reg;
    logic          err_reg;
    logic [VW-1:0] out_data_reg;
    logic          first_out_reg;

    logic in_beat;
    logic bad_value;
    logic tmo_hit;

    // A write beat is gated by rst_n so nothing reaches memory while in reset.
    assign in_beat   = rst_n && (state_reg == LOAD) && bus.i_in_valid;
    assign bad_value = (bus.i_in_data > MAX_VAL);
    assign tmo_hit   = (bus.i_timeout_limit != '0) &&
                       (tmo_cnt_reg == bus.i_timeout_limit - TW'(1));

    assign bus.o_in_ready     = (state_reg == LOAD);
    assign bus.o_busy         = (state_reg != LOAD);
    assign bus.o_solver_start = (state_reg == KICK);
    assign bus.o_mem_we       = in_beat;
    assign bus.o_mem_re       = (state_reg == RD_REQ);
    assign bus.o_mem_addr     = (in_beat || state_reg == RD_REQ) ? cell_cnt_reg : '0;
    assign bus.o_mem_wdata    = (in_beat && !bad_value) ? bus.i_in_data : '0;
    assign bus.o_out_valid    = (state_reg == RD_OUT);
    // First RD_OUT cycle passes read data straight through so a beat can
    // complete every two cycles; afterwards the captured copy holds it stable.
    assign bus.o_out_data     = (state_reg != RD_OUT) ? '0 :
                                (first_out_reg ? bus.i_mem_rdata : out_data_reg);
    assign bus.o_out_last     = (state_reg == RD_OUT) && (cell_cnt_reg == LAST_CELL);
    assign bus.o_timeout      = timeout_reg;
    assign bus.o_err_value    = err_reg;

    // Main sequencer: load, kick, wait/timeout, read-out loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= LOAD;
            cell_cnt_reg  <= '0;
            tmo_cnt_reg   <= '0;
            timeout_reg   <= 1'b0;
            err_reg       <= 1'b0;
            out_data_reg  <= '0;
            first_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (bus.i_in_valid) begin
                        // New board clears the sticky flags; a bad first cell
                        // still sets the error below.
                        if (cell_cnt_reg == '0) begin
                            err_reg     <= 1'b0;
                            timeout_reg <= 1'b0;
                        end
                        if (bad_value) begin
                            err_reg <= 1'b1;
                        end
                        if (cell_cnt_reg == LAST_CELL) begin
                            cell_cnt_reg <= '0;
                            state_reg    <= KICK;
                        end else begin
                            cell_cnt_reg <= cell_cnt_reg + AW'(1);
                        end
                    end
                end
                KICK: begin
                    tmo_cnt_reg <= '0;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    // Done beats a simultaneous timeout.
                    if (bus.i_solver_done) begin
                        state_reg <= RD_REQ;
                    end else begin
                        if (tmo_cnt_reg != '1) begin
                            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                        end
                        if (tmo_hit) begin
                            timeout_reg <= 1'b1;
                            state_reg   <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    first_out_reg <= 1'b1;
                    state_reg     <= RD_OUT;
                end
                RD_OUT: begin
                    first_out_reg <= 1'b0;
                    if (first_out_reg) begin
                        out_data_reg <= bus.i_mem_rdata;
                    end
                    if (bus.i_out_ready) begin
                        if (cell_cnt_reg == LAST_CELL) begin
                            cell_cnt_reg <= '0;
                            state_reg    <= LOAD;
                        end else begin
                            cell_cnt_reg <= cell_cnt_reg + AW'(1);
                            state_reg    <= RD_REQ;
                        end
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end
endmodule
